// File: rtl/arm_mem_pkg.sv
// arm_mem_pkg: shared state encoding, MEM/WB payload and constants for the
// memory stage of the pipelined ARM core.
package arm_mem_pkg;

    typedef enum logic {
        IDLE,
        WAIT
    } mem_state_e;

    localparam logic [31:0] BUS_ERR_DATA_DEF = 32'hDEAD_BEEF;

    typedef struct packed {
        logic [31:0] alu_out;
        logic [31:0] read_data;
        logic [3:0]  wa3;
        logic        reg_write;
        logic        mem_to_reg;
        logic        pc_src;
    } mem_wb_t;

    // Wait counter must hold values up to TIMEOUT.
    function automatic int cnt_width(input int timeout);
        return $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/pipe_mem_wb.sv
// pipe_mem_wb: MEM/WB pipeline register; a bubble clears the control bits
// and holds the data fields.
module pipe_mem_wb
    import arm_mem_pkg::*;
(
    input  logic    clk,
    input  logic    rst_n,
    input  logic    bubble,
    input  mem_wb_t d,
    output mem_wb_t q
);

    mem_wb_t wb_d, wb_q;

    always_comb begin
        wb_d = d;
        if (bubble) begin
            wb_d            = wb_q;
            wb_d.reg_write  = 1'b0;
            wb_d.mem_to_reg = 1'b0;
            wb_d.pc_src     = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) wb_q <= '0;
        else        wb_q <= wb_d;
    end

    assign q = wb_q;

endmodule

// File: rtl/mem_stage.sv
// mem_stage: word load/store over a variable-latency req/ack bus with
// stall generation, access timeout, sticky bus error and the MEM/WB register.
module mem_stage
    import arm_mem_pkg::*;
#(
    parameter int          TIMEOUT      = 16,
    parameter logic [31:0] BUS_ERR_DATA = BUS_ERR_DATA_DEF
) (
    input  logic        Clk,
    input  logic        reset,
    input  logic [31:0] AToMemIn,
    input  logic [31:0] WDToMemIn,
    input  logic [3:0]  WA3Min,
    input  logic        RegWriteMin,
    input  logic        MemToRegMin,
    input  logic        MemWriteMin,
    input  logic        PCSrcMin,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        StallM,
    output logic [31:0] ALUOutMfwd,
    output logic [31:0] ReadDataW,
    output logic [31:0] ALUOutW,
    output logic [3:0]  WA3W,
    output logic        RegWriteW,
    output logic        MemToRegW,
    output logic        PCSrcW,
    output logic        bus_err
);

    localparam int CW = cnt_width(TIMEOUT);

    mem_state_e    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          bus_err_q, bus_err_d;
    logic          acc, aligned, is_load, timeout_now, abort;
    mem_wb_t       wb_in, wb_out;

    // Request is gated by reset so the bus sees nothing while held in reset.
    always_comb begin
        acc         = MemToRegMin | MemWriteMin;
        aligned     = AToMemIn[1:0] == 2'b00;
        is_load     = MemToRegMin & ~MemWriteMin;
        mem_req     = reset & acc & aligned;
        timeout_now = mem_req & ~mem_ack & (state_q == WAIT) & (cnt_q == CW'(TIMEOUT - 1));
        StallM      = mem_req & ~mem_ack & ~timeout_now;
        abort       = acc & (~aligned | timeout_now);
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bus_err_d = bus_err_q | abort;
        if (state_q == IDLE) begin
            if (mem_req && !mem_ack) begin
                state_d = WAIT;
                cnt_d   = CW'(1);
            end
        end else if (!mem_req || mem_ack || timeout_now) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bus_err_q <= bus_err_d;
        end
    end

    // Load data is only replaced by a load that completes or fails.
    always_comb begin
        wb_in.alu_out    = AToMemIn;
        wb_in.wa3        = WA3Min;
        wb_in.reg_write  = RegWriteMin & ~abort;
        wb_in.mem_to_reg = is_load;
        wb_in.pc_src     = PCSrcMin;
        wb_in.read_data  = wb_out.read_data;
        if (is_load && abort)
            wb_in.read_data = BUS_ERR_DATA;
        else if (is_load && mem_req && mem_ack)
            wb_in.read_data = mem_rdata;
    end

    pipe_mem_wb u_mem_wb (
        .clk    (Clk),
        .rst_n  (reset),
        .bubble (StallM),
        .d      (wb_in),
        .q      (wb_out)
    );

    assign mem_we     = MemWriteMin;
    assign mem_addr   = AToMemIn;
    assign mem_wdata  = WDToMemIn;
    assign ALUOutMfwd = AToMemIn;
    assign ReadDataW  = wb_out.read_data;
    assign ALUOutW    = wb_out.alu_out;
    assign WA3W       = wb_out.wa3;
    assign RegWriteW  = wb_out.reg_write;
    assign MemToRegW  = wb_out.mem_to_reg;
    assign PCSrcW     = wb_out.pc_src;
    assign bus_err    = bus_err_q;

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed and randomized instructions against a per-instruction
// behavioural model of the memory stage.
module tb_mem_stage;

    localparam int          TO   = 4;
    localparam logic [31:0] DEAD = 32'hDEAD_BEEF;

    logic        Clk = 1'b0, reset = 1'b0;
    logic [31:0] AToMemIn = '0, WDToMemIn = '0, mem_rdata = '0;
    logic [3:0]  WA3Min = '0;
    logic        RegWriteMin = 1'b0, MemToRegMin = 1'b0, MemWriteMin = 1'b0, PCSrcMin = 1'b0;
    logic        mem_ack = 1'b0;
    logic        mem_req, mem_we, StallM, RegWriteW, MemToRegW, PCSrcW, bus_err;
    logic [31:0] mem_addr, mem_wdata, ALUOutMfwd, ReadDataW, ALUOutW;
    logic [3:0]  WA3W;

    mem_stage #(.TIMEOUT(TO)) dut (
        .Clk(Clk), .reset(reset), .AToMemIn(AToMemIn), .WDToMemIn(WDToMemIn),
        .WA3Min(WA3Min), .RegWriteMin(RegWriteMin), .MemToRegMin(MemToRegMin),
        .MemWriteMin(MemWriteMin), .PCSrcMin(PCSrcMin), .mem_req(mem_req),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack), .StallM(StallM),
        .ALUOutMfwd(ALUOutMfwd), .ReadDataW(ReadDataW), .ALUOutW(ALUOutW),
        .WA3W(WA3W), .RegWriteW(RegWriteW), .MemToRegW(MemToRegW),
        .PCSrcW(PCSrcW), .bus_err(bus_err)
    );

    always #5 Clk = ~Clk;

    int   tests = 0, fails = 0, writes_seen = 0, writes_exp = 0, stall_cnt = 0;
    logic check_en = 1'b0, exp_req = 1'b0, exp_stall = 1'b0, exp_we = 1'b0;
    logic [31:0] m_alu = '0, m_rd = '0;
    logic [3:0]  m_wa3 = '0;
    logic        m_rw = 1'b0, m_mtr = 1'b0, m_pcs = 1'b0, m_err = 1'b0;

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge Clk) begin
        if (check_en) begin
            cmp("mem_req",    32'(mem_req),   32'(exp_req));
            cmp("StallM",     32'(StallM),    32'(exp_stall));
            cmp("mem_we",     32'(mem_we),    32'(exp_we));
            cmp("mem_addr",   mem_addr,       AToMemIn);
            cmp("mem_wdata",  mem_wdata,      WDToMemIn);
            cmp("ALUOutMfwd", ALUOutMfwd,     AToMemIn);
            cmp("ALUOutW",    ALUOutW,        m_alu);
            cmp("ReadDataW",  ReadDataW,      m_rd);
            cmp("WA3W",       32'(WA3W),      32'(m_wa3));
            cmp("RegWriteW",  32'(RegWriteW), 32'(m_rw));
            cmp("MemToRegW",  32'(MemToRegW), 32'(m_mtr));
            cmp("PCSrcW",     32'(PCSrcW),    32'(m_pcs));
            cmp("bus_err",    32'(bus_err),   32'(m_err));
        end
        if (StallM) stall_cnt++;
    end

    always @(posedge Clk) if (reset && mem_req && mem_ack && mem_we) writes_seen++;

    // lat: bus cycle of the ack (0 or >TO never acks); for non-bus ops nonzero drives a stray ack.
    task automatic run_instr(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] wa3,
                             input logic rw, input logic mtr, input logic mw, input logic pcs,
                             input int lat, input logic [31:0] rdata);
        logic acc, al, ld, ok, err;
        int   n;
        acc = mtr | mw;
        al  = (a[1:0] == 2'b00);
        ld  = mtr & ~mw;
        ok  = (lat >= 1 && lat <= TO);
        n   = (acc && al) ? (ok ? lat : TO) : 1;
        for (int k = 1; k <= n; k++) begin
            AToMemIn = a; WDToMemIn = wd; WA3Min = wa3; RegWriteMin = rw;
            MemToRegMin = mtr; MemWriteMin = mw; PCSrcMin = pcs; mem_rdata = rdata;
            mem_ack   = (acc && al) ? (ok && k == lat) : (lat != 0);
            exp_req   = acc && al;
            exp_stall = acc && al && k < n;
            exp_we    = mw;
            @(posedge Clk); #1;
            mem_ack = 1'b0;
            if (k < n) begin
                m_rw = 1'b0; m_mtr = 1'b0; m_pcs = 1'b0;
            end else begin
                err   = acc && (!al || !ok);
                m_alu = a; m_wa3 = wa3; m_mtr = ld; m_pcs = pcs; m_rw = rw && !err;
                if (err) m_err = 1'b1;
                if (ld) m_rd = err ? DEAD : rdata;
                if (acc && al && ok && mw) writes_exp++;
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1);
    end

    initial begin
        int s0, w0, kind, lat;
        logic [31:0] a;
        AToMemIn = 32'h104; MemToRegMin = 1'b1;
        repeat (3) @(posedge Clk);
        #1;
        cmp("rst mem_req",   32'(mem_req),   0);
        cmp("rst StallM",    32'(StallM),    0);
        cmp("rst RegWriteW", 32'(RegWriteW), 0);
        cmp("rst ReadDataW", ReadDataW,      0);
        cmp("rst bus_err",   32'(bus_err),   0);
        MemToRegMin = 1'b0;
        reset = 1'b1;
        check_en = 1'b1;

        run_instr(32'h10, 32'h0, 4'd3, 1, 0, 0, 0, 0, 32'h0);
        cmp("alu ALUOutW",   ALUOutW,        32'h10);
        cmp("alu WA3W",      32'(WA3W),      3);
        cmp("alu RegWriteW", 32'(RegWriteW), 1);

        s0 = stall_cnt;
        run_instr(32'h100, 32'h0, 4'd5, 1, 1, 0, 0, 1, 32'hCAFE_F00D);
        cmp("zw stalls",    stall_cnt - s0, 0);
        cmp("zw ReadDataW", ReadDataW,      32'hCAFE_F00D);
        cmp("zw MemToRegW", 32'(MemToRegW), 1);

        s0 = stall_cnt; w0 = writes_seen;
        run_instr(32'h200, 32'h55, 4'd0, 0, 0, 1, 0, 3, 32'h0);
        cmp("st stalls",  stall_cnt - s0,   2);
        cmp("st writes",  writes_seen - w0, 1);
        cmp("st bus_err", 32'(bus_err),     0);

        s0 = stall_cnt;
        run_instr(32'h400, 32'h0, 4'd6, 1, 1, 0, 0, 0, 32'h1234_5678);
        cmp("to stalls",    stall_cnt - s0, 3);
        cmp("to ReadDataW", ReadDataW,      32'hDEAD_BEEF);
        cmp("to RegWriteW", 32'(RegWriteW), 0);
        cmp("to bus_err",   32'(bus_err),   1);
        run_instr(32'h8, 32'h0, 4'd1, 1, 0, 0, 0, 0, 32'h0);

        s0 = stall_cnt;
        run_instr(32'h102, 32'h0, 4'd2, 1, 1, 0, 0, 1, 32'h0BAD_0BAD);
        cmp("mis stalls",    stall_cnt - s0, 0);
        cmp("mis RegWriteW", 32'(RegWriteW), 0);
        cmp("mis ReadDataW", ReadDataW,      32'hDEAD_BEEF);

        AToMemIn = 32'h300; MemToRegMin = 1'b1; MemWriteMin = 1'b0; RegWriteMin = 1'b1;
        mem_ack = 1'b0; exp_req = 1'b1; exp_stall = 1'b1; exp_we = 1'b0;
        @(posedge Clk); #1;
        m_rw = 1'b0; m_mtr = 1'b0; m_pcs = 1'b0;
        @(negedge Clk); #2;
        check_en = 1'b0;
        reset = 1'b0;
        #1;
        cmp("arst mem_req",   32'(mem_req),   0);
        cmp("arst StallM",    32'(StallM),    0);
        cmp("arst ReadDataW", ReadDataW,      0);
        cmp("arst ALUOutW",   ALUOutW,        0);
        cmp("arst WA3W",      32'(WA3W),      0);
        cmp("arst RegWriteW", 32'(RegWriteW), 0);
        cmp("arst bus_err",   32'(bus_err),   0);
        m_alu = '0; m_rd = '0; m_wa3 = '0; m_rw = 1'b0; m_mtr = 1'b0; m_pcs = 1'b0; m_err = 1'b0;
        MemToRegMin = 1'b0; RegWriteMin = 1'b0;
        @(posedge Clk); #1;
        reset = 1'b1;
        check_en = 1'b1;
        run_instr(32'h44, 32'h0, 4'd7, 1, 0, 0, 0, 1, 32'h7777_7777);
        cmp("stray ReadDataW", ReadDataW, 0);
        s0 = stall_cnt;
        run_instr(32'h500, 32'h0, 4'd9, 1, 1, 0, 1, 1, 32'h0F0F_1234);
        cmp("post-rst stalls", stall_cnt - s0, 0);

        for (int i = 0; i < 1500; i++) begin
            a = $urandom;
            if ($urandom_range(0, 7) != 0) a[1:0] = 2'b00;
            kind = $urandom_range(0, 3);
            lat  = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, TO + 1);
            run_instr(a, $urandom, 4'($urandom), 1'($urandom), kind == 1 || kind == 3,
                      kind >= 2, 1'($urandom), lat, $urandom);
        end
        check_en = 1'b0;
        cmp("total writes", writes_seen, writes_exp);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
Memory stage of the pipelined ARM core. It sits directly downstream of the execute stage's EX/MEM register and consumes its address, write data, WA3 and control bits. It performs word loads and stores over a variable-latency req/ack data bus shared with the camera frame memory, and asserts a stall while an access is outstanding. It owns the MEM/WB pipeline register feeding writeback.

Parameters:
TIMEOUT, 16, maximum cycles mem_req may stay high without mem_ack before the access is aborted; legal range 2..255.
BUS_ERR_DATA, 32'hDEAD_BEEF, value loaded into ReadDataW on an aborted or rejected load.

Ports:
Clk  in  1  clock; all state updates on the rising edge.
reset  in  1  asynchronous, active-low reset.
AToMemIn  in  32  ALU result / data address from EX/MEM.
WDToMemIn  in  32  store data from EX/MEM.
WA3Min  in  4  destination register.
RegWriteMin  in  1  register write enable (already cond-gated).
MemToRegMin  in  1  load instruction.
MemWriteMin  in  1  store instruction.
PCSrcMin  in  1  PC write (already cond-gated).
mem_req  out  1  bus request.
mem_we  out  1  1 = write.
mem_addr  out  32  word address (= AToMemIn).
mem_wdata  out  32  store data (= WDToMemIn).
mem_rdata  in  32  read data, valid when mem_ack = 1.
mem_ack  in  1  one-cycle completion strobe.
StallM  out  1  to hazard unit; freezes F/D/E and EX/MEM while 1.
ALUOutMfwd  out  32  = AToMemIn; forwarding source for execute.
ReadDataW  out  32  registered load data.
ALUOutW  out  32  registered ALU result.
WA3W  out  4  registered destination.
RegWriteW, MemToRegW, PCSrcW  out  1 each  registered controls.
bus_err  out  1  sticky error flag, cleared only by reset.

Behaviour:
- Reset (reset = 0, asynchronous):
  - All W outputs, bus_err and the wait counter go to 0; FSM goes to IDLE.
  - mem_req and StallM are forced to 0 while reset is low.
  - An access in flight is abandoned with no writeback.
- Access condition: acc = MemToRegMin | MemWriteMin. If both are set, the store wins: mem_we = 1 and no register load occurs.
- Misaligned access (acc and AToMemIn[1:0] != 0):
  - mem_req stays 0 and StallM stays 0.
  - bus_err is set. The W register captures the instruction with RegWriteW = 0.
  - For a misaligned load, ReadDataW = BUS_ERR_DATA.
- mem_req = acc & aligned & (state == IDLE | state == WAIT). It is combinational, so a zero-wait memory needs no stall.
- mem_we = MemWriteMin, mem_addr = AToMemIn, mem_wdata = WDToMemIn. These are held stable by the upstream freeze.
- StallM = mem_req & ~mem_ack & ~timeout_now.
- FSM states:
  - IDLE, with mem_req and no ack: go to WAIT and set counter = 1.
  - IDLE, with ack or no access: stay in IDLE.
  - WAIT, with ack: go to IDLE.
  - WAIT, with counter == TIMEOUT-1 and no ack: set timeout_now. This aborts the access: go to IDLE, set bus_err, StallM = 0, RegWriteW = 0, ReadDataW = BUS_ERR_DATA. mem_req drops next cycle.
  - WAIT, otherwise: counter increments.
  - Result: mem_req is high for at most TIMEOUT cycles.
- MEM/WB register, each edge:
  - If StallM = 1: load a bubble (RegWriteW = 0, PCSrcW = 0, MemToRegW = 0; data fields don't-care but held).
  - Else: capture the M inputs, with ReadDataW = mem_rdata when a load is acked.
- Latency:
  - Non-memory ops and zero-wait accesses take 1 cycle (M to W).
  - An access acked in bus cycle N stalls N-1 cycles.
- A mem_ack arriving in IDLE with no request is ignored. The bus must drop ack after one cycle.

Decomposition:
- Package arm_mem_pkg holds:
  - the state enum (IDLE, WAIT);
  - the default BUS_ERR_DATA constant;
  - the counter-width function $clog2(TIMEOUT+1).
- Sub-module pipe_mem_wb is the MEM/WB register with async active-low reset and a bubble input driven by StallM.
- The FSM, counter and bus logic stay in mem_stage.

Test Plan:
- ALU op: RegWriteMin = 1, AToMemIn = 0x10, WA3Min = 3 -> next edge ALUOutW = 0x10, WA3W = 3, RegWriteW = 1; mem_req and StallM never 1.
- Zero-wait load: MemToRegMin = 1, addr 0x100, mem_ack same cycle with mem_rdata = 0xCAFEF00D -> StallM stays 0; next edge ReadDataW = 0xCAFEF00D, MemToRegW = 1.
- 3-cycle store: MemWriteMin = 1, addr 0x200, WD 0x55, ack on the 3rd cycle -> mem_we = 1 and mem_wdata = 0x55 stable; StallM high for 2 cycles with a W bubble each; one write seen; then IDLE.
- Timeout with TIMEOUT = 4 and no ack on a load -> StallM high cycles 1-3, low on cycle 4; bus_err = 1, ReadDataW = 0xDEADBEEF, RegWriteW = 0; mem_req low on cycle 5.
- Misaligned load at 0x102 -> mem_req 0, StallM 0, bus_err = 1, RegWriteW = 0.
- reset driven low during WAIT -> all outputs 0 immediately, FSM in IDLE; a later stray mem_ack is ignored.
